// File: rtl/regfile_wb_sched_pkg.sv
// Shared types for the register-file writeback scheduler.
// Address/data widths, writeback request bundle and source ids.
package regfile_wb_sched_pkg;

  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] u32_t;

  localparam int NUM_REGS = 32;

  typedef struct packed {
    regaddr_t addr;
    u32_t     data;
  } wb_req_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Writeback, issue and decode-hazard signals of the scheduler.
// master drives requests; slave is the scheduler.
interface regfile_wb_sched_if;
  import regfile_wb_sched_pkg::*;

  logic     alu_valid;
  logic     alu_ready;
  regaddr_t alu_addr;
  u32_t     alu_data;
  logic     lsu_valid;
  logic     lsu_ready;
  regaddr_t lsu_addr;
  u32_t     lsu_data;
  logic     issue_valid;
  logic     issue_ready;
  regaddr_t issue_addr;
  regaddr_t ra_addr;
  regaddr_t rb_addr;
  logic     ra_busy;
  logic     rb_busy;
  regaddr_t rd_addr;
  u32_t     rd_data;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    output issue_valid, issue_addr,
    output ra_addr, rb_addr,
    input  alu_ready, lsu_ready, issue_ready,
    input  ra_busy, rb_busy,
    input  rd_addr, rd_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    input  issue_valid, issue_addr,
    input  ra_addr, rb_addr,
    output alu_ready, lsu_ready, issue_ready,
    output ra_busy, rb_busy,
    output rd_addr, rd_data
  );

endinterface

// File: rtl/regfile_wb_sched_wb_arb2.sv
// Two-requester arbiter, round-robin or fixed LSU priority.
// Bit WB_ALU / WB_LSU of req and gnt belong to each source.
module wb_arb2
  import regfile_wb_sched_pkg::*;
#(
  parameter bit FIXED = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic pref_lsu;
  logic both;

  assign both = req[WB_ALU] & req[WB_LSU];

  always_comb begin
    gnt = req;
    if (both) begin
      gnt = (FIXED || pref_lsu) ? 2'b10 : 2'b01;
    end
  end

  // Pointer moves only when both sources compete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pref_lsu <= 1'b0;
    end else if (both) begin
      pref_lsu <= gnt[WB_ALU];
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler with per-register busy scoreboard.
// Arbitrates ALU/LSU writebacks into a one-cycle output stage.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int NUM_REGS       = regfile_wb_sched_pkg::NUM_REGS,
  parameter int LSU_FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_sched_if.slave bus
);

  if (NUM_REGS != (1 << $bits(regaddr_t))) begin : g_bad_size
    $error("NUM_REGS must equal 2**width of regaddr_t");
  end

  wb_req_t             alu_req;
  wb_req_t             lsu_req;
  wb_req_t             win_req;
  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                accept;
  logic                issue_fire;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  regaddr_t            rd_addr_q;
  u32_t                rd_data_q;

  assign alu_req = '{addr: bus.alu_addr, data: bus.alu_data};
  assign lsu_req = '{addr: bus.lsu_addr, data: bus.lsu_data};

  assign req[WB_ALU] = bus.alu_valid;
  assign req[WB_LSU] = bus.lsu_valid;

  wb_arb2 #(
    .FIXED (LSU_FIXED_PRIO != 0)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign bus.alu_ready = gnt[WB_ALU];
  assign bus.lsu_ready = gnt[WB_LSU];
  assign accept        = |gnt;
  assign win_req       = gnt[WB_LSU] ? lsu_req : alu_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_addr_q <= accept ? win_req.addr : '0;
      if (accept) begin
        rd_data_q <= win_req.data;
      end
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_data = rd_data_q;

  // A committing register still reads busy, so a WAW reissue waits a cycle.
  assign bus.issue_ready = (bus.issue_addr == '0) | ~busy[bus.issue_addr];
  assign issue_fire      = bus.issue_valid & bus.issue_ready;

  always_comb begin
    busy_nxt = busy;
    if (rd_addr_q != '0) begin
      busy_nxt[rd_addr_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_nxt[bus.issue_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign bus.ra_busy = busy[bus.ra_addr];
  assign bus.rb_busy = busy[bus.rb_addr];

  // Every committed writeback must target a reserved register.
  a_wb_reserved: assert property (
    @(posedge clk) disable iff (rst)
    (rd_addr_q != '0) |-> busy[rd_addr_q]
  );

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-port scheduler and scoreboard for the 32-entry register file. The register file has two read ports and a single write port (rd_addr/rd_data); writes to r0 are discarded.
- Arbitrates the ALU and LSU writeback streams onto that single write port with valid/ready handshakes.
- Tracks a per-register busy bit: set when the issue stage reserves a destination, cleared when the write commits.
- Gives decode hazard flags for both read-port addresses.

Parameters:
- NUM_REGS, 32, register count. Must equal 2**width of regaddr_t.
- LSU_FIXED_PRIO, 0, arbitration mode. 0 = round-robin between ALU and LSU; 1 = LSU always wins.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_addr  in  5  ALU destination (regaddr_t).
- alu_data  in  32  ALU result (u32_t).
- lsu_valid  in  1  LSU writeback request.
- lsu_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  5  LSU destination.
- lsu_data  in  32  LSU load data.
- issue_valid  in  1  issue stage reserves a destination.
- issue_ready  out  1  reservation accepted this cycle.
- issue_addr  in  5  destination to reserve.
- ra_addr  in  5  decode read address A.
- rb_addr  in  5  decode read address B.
- ra_busy  out  1  ra_addr has a pending write.
- rb_busy  out  1  rb_addr has a pending write.
- rd_addr  out  5  register-file write address (0 = no write).
- rd_data  out  32  register-file write data.

Behaviour:
- Reset (async, rst=1): all busy bits clear, rd_addr=0, rd_data=0, round-robin pointer favours ALU next. alu_ready, lsu_ready and issue_ready follow their combinational equations from the cleared state.
- Reset mid-operation: any write held in the output stage is dropped (no commit). Reservations are lost.

Arbitration (combinational):
- Handshakes are valid&ready. ready never depends on the requester's own data.
- Only one valid requester: it is granted.
- Both valid, LSU_FIXED_PRIO=1: LSU granted.
- Both valid, LSU_FIXED_PRIO=0: the source not granted at the most recent contended cycle is granted. The pointer updates only on contended cycles.
- ready=1 only for the granted source. The output stage drains every cycle, so the port never back-pressures beyond arbitration.

Output stage:
- Accepted request is registered: rd_addr/rd_data hold {addr,data} for exactly one cycle. The register file commits at the following edge.
- Total latency: accept at edge N, commit at edge N+1.
- No accept in a cycle: rd_addr=0 next cycle; rd_data holds its last value.
- Accepted addr=0: handshake completes, rd_addr=0, no busy change.

Scoreboard:
- busy[r] clears at the edge where rd_addr=r commits (r≠0).
- busy[r] sets at the edge of an issue handshake to r≠0.
- Set and clear of the same register in the same cycle: set wins.
- busy[0] is hard-wired 0.
- issue_ready = (issue_addr==0) | ~busy[issue_addr]. This stalls WAW hazards, including a register that is committing this cycle (conservative).
- ra_busy = busy[ra_addr], combinational with no bypass. rb_busy likewise.
- The reader stalls until the cycle after commit, when the register file holds the new value.

Protocol assumptions and checks:
- A writeback to a non-busy register (other than r0) is a protocol error. Guard it with an assertion; it must not corrupt other bits.

Decomposition:
- Shared types package additions: NUM_REGS constant; wb_req_t struct {regaddr_t addr; u32_t data}; wb_src_e enum {WB_ALU, WB_LSU}.
- Sub-module wb_arb2: two-requester arbiter (round-robin/fixed) taking valids and returning one-hot grant. Pointer register on the same async rst.
- The scoreboard and output stage stay in regfile_wb_sched.

Test Plan:
- Reset with all valids high: after rst release, rd_addr=0, ra_busy=rb_busy=0, issue_ready=1, alu_ready=1, lsu_ready=0 (first contention goes to ALU).
- Issue r5; ra_addr=5 → ra_busy=1 next cycle. ALU writes r5=0x1234_5678 → alu_ready=1; rd_addr=5/rd_data=0x12345678 next cycle; ra_busy=0 the cycle after.
- ALU and LSU both valid for 4 cycles (targets r1 and r2), LSU_FIXED_PRIO=0 → grants alternate ALU, LSU, ALU, LSU; rd_addr sequence 1, 2, 1, 2. With LSU_FIXED_PRIO=1 → rd_addr 2, 2, 2, 2 and alu_ready=0 throughout.
- Issue r7 twice back-to-back → second issue_ready=0 until LSU commits r7. Issue r7 in the same cycle r7 commits → still stalls, then accepted next cycle with busy[7]=1.
- issue_addr=0 and alu_addr=0 writeback → issue_ready=1, no busy change, rd_addr stays 0; rb_addr=0 → rb_busy=0.
- Assert rst for 1 cycle while rd_addr=9 is pending and busy[3]=1 → rd_addr=0 immediately, busy[3]=0, register 9 is not written.
